// File: rtl/pu_layer_scheduler.sv
// Layer sequencer between the top-level start and the PU controller/datapath.
// Reads one config word per layer, issues PU passes and enforces a drain gap between layers.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   S_IDLE       | waiting for start
//   S_CFG_RD     | config ROM address presented, waiting one cycle of latency
//   S_CFG_LATCH  | capture {pool, l_type, oc, ic}, reset pass indices and write count
//   S_PASS_START | one-cycle pass_start pulse
//   S_PASS_WAIT  | waiting for pass_done from the PU controller
//   S_PASS_NEXT  | advance ic/oc indices or finish the layer
//   S_DRAIN      | fixed idle interval before the next config read
//   S_DONE       | one-cycle done pulse
module pu_layer_scheduler #(
    parameter int LAYER_ID_W        = 4,
    parameter int LAYER_PARAM_WIDTH = 10,
    parameter int L_TYPE_WIDTH      = 2,
    parameter int WR_CNT_W          = 16,
    parameter int DRAIN_CYCLES      = 100
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           start,
    input  logic [LAYER_ID_W-1:0]                          max_layers,
    output logic [LAYER_ID_W-1:0]                          cfg_addr,
    input  logic [1+L_TYPE_WIDTH+2*LAYER_PARAM_WIDTH-1:0]  cfg_data,
    output logic                                           pass_start,
    input  logic                                           pass_done,
    input  logic                                           write_req,
    output logic [LAYER_ID_W-1:0]                          layer_id,
    output logic [L_TYPE_WIDTH-1:0]                        layer_type,
    output logic                                           pool_en,
    output logic [LAYER_PARAM_WIDTH-1:0]                   ic_idx,
    output logic [LAYER_PARAM_WIDTH-1:0]                   oc_idx,
    output logic [WR_CNT_W-1:0]                            layer_wr_count,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           spurious_done
);

    localparam int CFG_W = 1 + L_TYPE_WIDTH + 2 * LAYER_PARAM_WIDTH;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_RD,
        S_CFG_LATCH,
        S_PASS_START,
        S_PASS_WAIT,
        S_PASS_NEXT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                       state, state_nxt;
    logic [LAYER_PARAM_WIDTH-1:0] ic_max, oc_max;
    logic [DRN_W-1:0]             drain_cnt;
    logic                         is_conv;
    logic                         last_pass;
    logic                         drain_tc;
    logic                         grp_clr;
    logic                         wr_clr;

    // Reserved type 3 is issued like a convolution.
    assign is_conv   = (layer_type == L_TYPE_WIDTH'(0)) || (layer_type == L_TYPE_WIDTH'(3));
    assign last_pass = (ic_idx == ic_max) && (oc_idx == oc_max);
    assign drain_tc  = (drain_cnt == '0);
    assign grp_clr   = (state == S_PASS_NEXT) && is_conv && (ic_idx == ic_max) && !last_pass;
    assign wr_clr    = (state == S_CFG_LATCH) || grp_clr;

    assign cfg_addr   = layer_id;
    assign pass_start = (state == S_PASS_START);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start) state_nxt = S_CFG_RD;
            S_CFG_RD:     state_nxt = S_CFG_LATCH;
            S_CFG_LATCH:  state_nxt = S_PASS_START;
            S_PASS_START: state_nxt = S_PASS_WAIT;
            S_PASS_WAIT:  if (pass_done) state_nxt = S_PASS_NEXT;
            S_PASS_NEXT:  state_nxt = (is_conv && !last_pass) ? S_PASS_START : S_DRAIN;
            S_DRAIN: begin
                if (drain_tc) state_nxt = (layer_id == max_layers) ? S_DONE : S_CFG_RD;
            end
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            layer_id   <= '0;
            layer_type <= '0;
            pool_en    <= 1'b0;
            ic_max     <= '0;
            oc_max     <= '0;
            ic_idx     <= '0;
            oc_idx     <= '0;
            drain_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) layer_id <= '0;
                end
                S_CFG_LATCH: begin
                    ic_max     <= cfg_data[LAYER_PARAM_WIDTH-1:0];
                    oc_max     <= cfg_data[2*LAYER_PARAM_WIDTH-1:LAYER_PARAM_WIDTH];
                    layer_type <= cfg_data[2*LAYER_PARAM_WIDTH+L_TYPE_WIDTH-1:2*LAYER_PARAM_WIDTH];
                    pool_en    <= cfg_data[CFG_W-1];
                    ic_idx     <= '0;
                    oc_idx     <= '0;
                end
                S_PASS_NEXT: begin
                    if (is_conv && !last_pass) begin
                        if (ic_idx < ic_max) begin
                            ic_idx <= ic_idx + LAYER_PARAM_WIDTH'(1);
                        end else begin
                            ic_idx <= '0;
                            oc_idx <= oc_idx + LAYER_PARAM_WIDTH'(1);
                        end
                    end else begin
                        drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
                    end
                end
                S_DRAIN: begin
                    if (drain_tc) begin
                        if (layer_id != max_layers) layer_id <= layer_id + LAYER_ID_W'(1);
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A clear that coincides with a write leaves that write counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            layer_wr_count <= '0;
        end else if (wr_clr) begin
            layer_wr_count <= write_req ? WR_CNT_W'(1) : '0;
        end else if (write_req && busy && (layer_wr_count != {WR_CNT_W{1'b1}})) begin
            layer_wr_count <= layer_wr_count + WR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spurious_done <= 1'b0;
        end else if (pass_done && (state != S_PASS_WAIT)) begin
            spurious_done <= 1'b1;
        end else if ((state == S_IDLE) && start) begin
            spurious_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pu_layer_scheduler.sv
// Self-checking bench for pu_layer_scheduler: directed scenarios plus randomized networks
// checked against a pass-list model built from the config ROM contents.
module tb_pu_layer_scheduler;

    localparam int LID = 4;
    localparam int LPW = 10;
    localparam int LTW = 2;
    localparam int WCW = 16;
    localparam int D   = 8;
    localparam int CW  = 1 + LTW + 2 * LPW;

    logic           clk = 1'b0;
    logic           reset, start, pass_done, write_req;
    logic [LID-1:0] max_layers, cfg_addr, layer_id;
    logic [CW-1:0]  cfg_data;
    logic           pass_start, pool_en, busy, done, spurious_done;
    logic [LTW-1:0] layer_type;
    logic [LPW-1:0] ic_idx, oc_idx;
    logic [WCW-1:0] layer_wr_count;

    logic [CW-1:0]  rom [16];
    int             cyc = 0;
    int             n_checks = 0;
    int             n_fail = 0;

    typedef struct {
        int l; int o; int i; int t; int p; bit last;
    } pass_t;

    pass_t exp_q[$];
    int    wr_n[$];
    bit    extra[$];

    pu_layer_scheduler #(
        .LAYER_ID_W(LID), .LAYER_PARAM_WIDTH(LPW), .L_TYPE_WIDTH(LTW),
        .WR_CNT_W(WCW), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .max_layers(max_layers),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .pass_start(pass_start),
        .pass_done(pass_done), .write_req(write_req), .layer_id(layer_id),
        .layer_type(layer_type), .pool_en(pool_en), .ic_idx(ic_idx), .oc_idx(oc_idx),
        .layer_wr_count(layer_wr_count), .busy(busy), .done(done),
        .spurious_done(spurious_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) cfg_data <= rom[cfg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] mk(input int p, input int t, input int oc, input int ic);
        logic [CW-1:0] w;
        w = {p[0], t[LTW-1:0], oc[LPW-1:0], ic[LPW-1:0]};
        return w;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass_start"}, pass_start, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_spur"}, spurious_done, 0);
        check({tag, "_ids"}, {cfg_addr, layer_id, ic_idx, oc_idx}, 0);
        check({tag, "_cfg"}, {layer_type, pool_en, layer_wr_count}, 0);
    endtask

    // Expected pass list: conv-like layers give (oc+1)x(ic+1) passes, types 1/2 give one.
    task automatic build_model();
        logic [CW-1:0] w;
        int ic, oc, t, p;
        exp_q.delete();
        for (int l = 0; l <= int'(max_layers); l++) begin
            w  = rom[l];
            ic = int'(w[LPW-1:0]);
            oc = int'(w[2*LPW-1:LPW]);
            t  = int'(w[2*LPW+LTW-1:2*LPW]);
            p  = int'(w[CW-1]);
            if (t == 1 || t == 2) begin
                exp_q.push_back('{l, 0, 0, t, p, 1'b1});
            end else begin
                for (int o = 0; o <= oc; o++)
                    for (int i = 0; i <= ic; i++)
                        exp_q.push_back('{l, o, i, t, p, (o == oc && i == ic)});
            end
        end
    endtask

    // wr_mode: 0 no writes, 1 random writes, 2 use caller-filled wr_n/extra.
    task automatic run_net(input int fixed_delay, input bit inj, input int wr_mode,
                           input int abort_layer, output bit aborted);
        int n_pass, p_idx, t_ref, gap_exp, tdone, twr_end, tnext, tcfg_old, tcfg_new;
        int t_reset, t_spur, old_l, grp, delay;
        bit extra_prev, exp_spur, finished;
        pass_t cur;
        aborted = 0;
        build_model();
        n_pass = exp_q.size();
        if (wr_mode != 2) begin
            wr_n.delete();
            extra.delete();
            for (int k = 0; k < n_pass; k++) begin
                wr_n.push_back(wr_mode == 1 ? int'($urandom_range(4, 0)) : 0);
                extra.push_back(wr_mode == 1 ? bit'($urandom_range(1, 0)) : 1'b0);
            end
        end
        @(negedge clk);
        start = 1'b1;
        t_ref = cyc; gap_exp = 3; exp_spur = 0;
        t_spur = inj ? cyc + 2 : -1;
        tdone = -1; twr_end = -1; tnext = -1; tcfg_old = -1; tcfg_new = -1; t_reset = -1;
        p_idx = 0; finished = 0; grp = 0; extra_prev = 0; old_l = 0;
        for (int k = 0; k < 5000 && !finished; k++) begin
            @(negedge clk);
            start = 1'b0; pass_done = 1'b0; write_req = 1'b0;
            if (cyc == t_ref + 1 && p_idx == 0) check("spur_cleared_on_start", spurious_done, 0);
            if (cyc == t_reset) begin
                #2 reset = 1'b0;
                #1 check_all_zero("mid_reset");
                aborted = 1; finished = 1;
            end else begin
                if (pass_start) begin
                    if (p_idx >= n_pass) begin
                        check("extra_pass_start", p_idx, n_pass - 1);
                    end else begin
                        cur = exp_q[p_idx];
                        check("pass_gap", cyc - t_ref, gap_exp);
                        check("layer_id", layer_id, cur.l);
                        check("cfg_addr", cfg_addr, cur.l);
                        check("oc_idx", oc_idx, cur.o);
                        check("ic_idx", ic_idx, cur.i);
                        check("layer_type", layer_type, cur.t);
                        check("pool_en", pool_en, cur.p);
                        check("busy", busy, 1);
                        if (cur.i == 0 && cur.o == 0) grp = 0;
                        else if (cur.i == 0)          grp = int'(extra_prev);
                        else                          grp = grp + int'(extra_prev);
                        check("wr_cnt_at_start", layer_wr_count, grp);
                        delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(12, 1));
                        if (delay < wr_n[p_idx]) delay = wr_n[p_idx];
                        tdone   = cyc + delay;
                        twr_end = cyc + wr_n[p_idx];
                        if (abort_layer == cur.l) t_reset = cyc + 2;
                        if (inj && $urandom_range(3, 0) == 0) begin
                            pass_done = 1'b1;
                            exp_spur  = 1;
                        end
                        if (inj && $urandom_range(3, 0) == 0) start = 1'b1;
                        p_idx++;
                    end
                end
                if (cyc < twr_end) write_req = 1'b1;
                if (cyc == t_spur) begin
                    pass_done = 1'b1;
                    exp_spur  = 1;
                end
                if (cyc == tnext) begin
                    check("wr_cnt_group", layer_wr_count, grp);
                    extra_prev = extra[p_idx-1];
                    write_req  = extra[p_idx-1];
                end
                if (cyc == tcfg_old) check("cfg_addr_hold", cfg_addr, old_l);
                if (cyc == tcfg_new) check("cfg_addr_step", cfg_addr, old_l + 1);
                if (done) begin
                    check("done_gap", cyc - t_ref, D + 2);
                    check("pass_count", p_idx, n_pass);
                    check("spur_flag", spurious_done, exp_spur);
                    check("layer_id_final", layer_id, max_layers);
                    finished = 1;
                end
                if (cyc == tdone) begin
                    pass_done = 1'b1;
                    t_ref = cyc;
                    tnext = cyc + 1;
                    grp   = grp + wr_n[p_idx-1];
                    if (p_idx == n_pass) begin
                        gap_exp = D + 2;
                    end else if (exp_q[p_idx-1].last) begin
                        gap_exp  = D + 4;
                        old_l    = exp_q[p_idx-1].l;
                        tcfg_old = cyc + D + 1;
                        tcfg_new = cyc + D + 2;
                    end else begin
                        gap_exp = 2;
                    end
                end
            end
        end
        if (!finished) check("run_timeout", 0, 1);
        if (!aborted) begin
            @(negedge clk);
            start = 1'b0; pass_done = 1'b0; write_req = 1'b0;
            check("idle_after_done_busy", busy, 0);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        bit ab;
        int ps, nl;
        reset = 1'b0; start = 1'b0; pass_done = 1'b0; write_req = 1'b0; max_layers = '0;
        for (int k = 0; k < 16; k++) rom[k] = '0;

        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_start_busy", busy, 0);
        check("idle_no_start_pass", pass_start, 0);

        // single conv layer ic=1 oc=2, fixed 10-cycle PU response
        rom[0] = mk(0, 0, 2, 1);
        max_layers = 0;
        run_net(10, 0, 0, -1, ab);

        // mixed network: conv(0,0), inner product, norm
        rom[0] = mk(0, 0, 0, 0);
        rom[1] = mk(1, 1, 5, 3);
        rom[2] = mk(0, 2, 2, 7);
        max_layers = 2;
        run_net(0, 0, 0, -1, ab);

        // write counting: 5 writes in group 0, one on the clearing cycle, 3 more in group 1
        rom[0] = mk(0, 0, 1, 1);
        max_layers = 0;
        wr_n.delete(); extra.delete();
        wr_n = '{2, 3, 1, 2};
        extra = '{1'b0, 1'b1, 1'b0, 1'b0};
        run_net(6, 0, 2, -1, ab);

        // spurious pass_done and start while busy
        rom[0] = mk(1, 0, 1, 2);
        rom[1] = mk(0, 3, 0, 1);
        max_layers = 1;
        run_net(0, 1, 1, -1, ab);
        run_net(0, 0, 1, -1, ab);

        // reset during PASS_WAIT of layer 1
        rom[0] = mk(0, 0, 0, 1);
        rom[1] = mk(0, 0, 1, 1);
        max_layers = 1;
        run_net(10, 0, 0, 1, ab);
        check("abort_reached", ab, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        pass_done = 1'b1;
        @(negedge clk);
        pass_done = 1'b0;
        ps = 0;
        repeat (20) begin
            @(negedge clk);
            if (pass_start) ps++;
        end
        check("post_reset_pass_start", ps, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_spur", spurious_done, 1);

        // randomized networks
        for (int r = 0; r < 10; r++) begin
            nl = int'($urandom_range(3, 0));
            max_layers = LID'(nl);
            for (int l = 0; l <= nl; l++)
                rom[l] = mk(int'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
            run_net(0, bit'($urandom_range(1, 0)), 1, -1, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
